reg_ctx_sequencer: RTL and testbench
====================================

# reg_ctx_sequencer

Exception-entry / exception-return sequencer that drives the register file's read/write port as its initiator. On an exception request it saves PC, CPSR and the syndrome into ELR, SPSR[mode] and ESR, then loads PC from EVP plus a vector offset. On an ERET request it restores PC from ELR and CPSR from SPSR[mode]. It sits in the core between the control unit and the register file, and owns the port whenever `busy` is high.

## Interface
- `DATA_W`, default `FISC_INTEGER_SZ` (64): register data width.
- `clk`  in  1  core clock; all state changes on the rising edge.
- `rst_n`  in  1  synchronous reset, active-low.
- `exc_req`  in  1  exception entry request; sampled only in IDLE.
- `exc_mode`  in  3  target SPSR bank; valid values 0..5 select register index 36+mode.
- `exc_vec`  in  8  vector number; new PC = EVP + {exc_vec, 4'b0}.
- `exc_syndrome`  in  DATA_W  value written to ESR.
- `eret_req`  in  1  exception return request; sampled only in IDLE.
- `eret_mode`  in  3  SPSR bank to restore from (0..5).
- `dout1`  in  DATA_W  register file read channel 1 data (combinational from `rd_reg1`).
- `rd_reg1`  out  6  register file read channel 1 index.
- `rd_reg2`  out  6  read channel 2 index; constant 0.
- `wr_reg`  out  6  register file write index.
- `wr`  out  1  register file write enable.
- `din`  out  DATA_W  register file write data.
- `set_flags`  out  1  constant 0.
- `busy`  out  1  high in every state except IDLE.
- `done`  out  1  one-cycle pulse when a sequence completes.
- `err`  out  1  one-cycle pulse when a request is rejected.

## Operation
- Register indices: PC=32, ESR=33, ELR=34, CPSR=35, SPSR=36..41, EVP=43.
- All port outputs are decoded from state flops only. `cap` is a DATA_W register loaded from `dout1` at the end of every RD state.
- Acceptance in IDLE:
  - `exc_req` has priority over `eret_req`.
  - The mode, vec and syndrome inputs are latched at acceptance. Input changes after acceptance are ignored.
  - Requests that arrive while `busy` is high are dropped and never queued.
- Mode > 5 goes to ERR (`err`=1 for one cycle), then to IDLE. No write is issued for a rejected request.
- Exception sequence (`wr`=0 in RD states, `wr`=1 in WR states):
  - X_RD_PC: `rd_reg1`=32.
  - X_WR_ELR: `wr_reg`=34, `din`=`cap`.
  - X_RD_CPSR: `rd_reg1`=35.
  - X_WR_SPSR: `wr_reg`=36+mode, `din`=zero-extended `cap[11:0]`.
  - X_WR_ESR: `wr_reg`=33, `din`=syndrome.
  - X_RD_EVP: `rd_reg1`=43.
  - X_WR_PC: `wr_reg`=32, `din`=`cap` + {vec, 4'b0}, modulo 2^DATA_W (carry discarded).
  - Then DONE, then IDLE.
- ERET sequence:
  - R_RD_ELR: `rd_reg1`=34.
  - R_WR_PC: `wr_reg`=32, `din`=`cap`.
  - R_RD_SPSR: `rd_reg1`=36+mode.
  - R_WR_CPSR: `wr_reg`=35, `din`=zero-extended `cap[11:0]`.
  - Then DONE, then IDLE.
- DONE: `done`=1, `wr`=0.
- In IDLE, DONE and ERR: `wr`=0, `rd_reg1`=0, `wr_reg`=0, `din`=0.

## Timing
- Reset (`rst_n` low at an edge) forces state=IDLE and `cap`=0. All outputs are 0 from the next cycle: `wr`, `rd_reg1`, `rd_reg2`, `wr_reg`, `din`, `set_flags`, `busy`, `done`, `err`.
- Reset during a sequence aborts it. Writes already committed stay committed. No `done` or `err` is produced for the aborted sequence.
- A request sampled at edge E0 makes the first sequence state active in cycle 1.
  - Exception: states in cycles 1..7, DONE in cycle 8, IDLE in cycle 9.
  - ERET: states in cycles 1..4, DONE in cycle 5.
  - Error: ERR in cycle 1, IDLE in cycle 2.
- A new request can be accepted at the edge that ends the IDLE cycle following DONE or ERR; there is no back-to-back acceptance in DONE.
- Each WR state is exactly one cycle. The register file commits the write at the edge that ends that cycle.

## Test plan
- Exception entry: PC=0x1000, CPSR=0x0A5, EVP=0x8000, mode=2, vec=3, syndrome=0xDEAD -> ELR=0x1000, reg38=0x0A5, ESR=0xDEAD, PC=0x8030; `done` in cycle 8; exactly 4 write cycles.
- ERET: ELR=0x2468, reg40=0x3C1, mode=4 -> PC=0x2468, CPSR=0x3C1; `done` in cycle 5; no other register changed.
- `exc_req` and `eret_req` high in the same cycle -> exception sequence only; a held `eret_req` is accepted in the IDLE cycle after DONE.
- Mode=6 on `exc_req`, and mode=7 on `eret_req` -> `err` pulse in cycle 1, `wr` never asserted, `busy` low by cycle 2.
- EVP=0xFFFF_FFFF_FFFF_FFF0, vec=1 -> PC=0 (wrap); a second `exc_req` pulse sent during cycles 2..7 is ignored.
- `rst_n` low in cycle 4 of an exception (X_WR_SPSR) -> ELR already written, SPSR unchanged; outputs and `busy` at 0 on the following cycle; no `done`.

Source files
------------

// File: rtl/reg_ctx_sequencer_if.sv
// rtl/reg_ctx_sequencer_if.sv - register file read/write port bundle
// Purpose: groups the register file port driven by reg_ctx_sequencer.
// Signals:
//   rd_reg1  read channel 1 index        rd_reg2    read channel 2 index
//   dout1    read channel 1 data         wr_reg     write index
//   wr       write enable                din        write data
//   set_flags flag-update strobe
// Modports: master = sequencer (initiator), slave = register file.
interface reg_ctx_sequencer_if #(
  parameter int DATA_W = 64
);
  logic [5:0]        rd_reg1;
  logic [5:0]        rd_reg2;
  logic [DATA_W-1:0] dout1;
  logic [5:0]        wr_reg;
  logic              wr;
  logic [DATA_W-1:0] din;
  logic              set_flags;

  modport master (
    output rd_reg1, rd_reg2, wr_reg, wr, din, set_flags,
    input  dout1
  );

  modport slave (
    input  rd_reg1, rd_reg2, wr_reg, wr, din, set_flags,
    output dout1
  );
endinterface

// File: rtl/reg_ctx_sequencer.sv
// rtl/reg_ctx_sequencer.sv - exception entry / return register context sequencer
// Purpose: on exc_req saves PC/CPSR/syndrome to ELR/SPSR[mode]/ESR and loads
// PC from EVP + {vec,4'b0}; on eret_req restores PC from ELR and CPSR from
// SPSR[mode]. Owns the register file port while busy.
// Ports:
//   clk, rst_n                 clock, synchronous active-low reset
//   exc_req/exc_mode/exc_vec/exc_syndrome  exception entry request
//   eret_req/eret_mode         exception return request
//   rf                         register file port (master side)
//   busy, done, err            status: not idle, completion pulse, reject pulse
module reg_ctx_sequencer #(
  parameter int DATA_W = 64
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                exc_req,
  input  logic [2:0]          exc_mode,
  input  logic [7:0]          exc_vec,
  input  logic [DATA_W-1:0]   exc_syndrome,
  input  logic                eret_req,
  input  logic [2:0]          eret_mode,
  reg_ctx_sequencer_if.master rf,
  output logic                busy,
  output logic                done,
  output logic                err
);
  localparam logic [5:0] REG_PC   = 6'd32;
  localparam logic [5:0] REG_ESR  = 6'd33;
  localparam logic [5:0] REG_ELR  = 6'd34;
  localparam logic [5:0] REG_CPSR = 6'd35;
  localparam logic [5:0] REG_SPSR = 6'd36;
  localparam logic [5:0] REG_EVP  = 6'd43;

  typedef enum logic [3:0] {
    IDLE, X_RD_PC, X_WR_ELR, X_RD_CPSR, X_WR_SPSR, X_WR_ESR, X_RD_EVP, X_WR_PC,
    R_RD_ELR, R_WR_PC, R_RD_SPSR, R_WR_CPSR, DONE, ERR
  } state_t;

  state_t            state, state_n;
  logic [DATA_W-1:0] cap;
  logic [DATA_W-1:0] syn_q;
  logic [2:0]        mode_q;
  logic [7:0]        vec_q;
  logic              cap_ld;
  logic              accept;
  logic [5:0]        spsr_idx;
  logic [DATA_W-1:0] cap_psr;
  logic [DATA_W-1:0] vec_off;

  assign accept   = (state == IDLE) && (exc_req || eret_req);
  assign spsr_idx = REG_SPSR + {3'b000, mode_q};
  // Saved/restored status words are only 12 bits wide.
  assign cap_psr  = {{(DATA_W-12){1'b0}}, cap[11:0]};
  assign vec_off  = {{(DATA_W-12){1'b0}}, vec_q, 4'b0000};

  assign rf.rd_reg2   = 6'd0;
  assign rf.set_flags = 1'b0;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state  <= IDLE;
      cap    <= '0;
      syn_q  <= '0;
      mode_q <= '0;
      vec_q  <= '0;
    end else begin
      state <= state_n;
      if (cap_ld) cap <= rf.dout1;
      if (accept) begin
        // exc_req wins, so its mode is the one checked and kept.
        mode_q <= exc_req ? exc_mode : eret_mode;
        vec_q  <= exc_vec;
        syn_q  <= exc_syndrome;
      end
    end
  end

  always_comb begin
    state_n    = state;
    rf.rd_reg1 = 6'd0;
    rf.wr_reg  = 6'd0;
    rf.wr      = 1'b0;
    rf.din     = '0;
    cap_ld     = 1'b0;
    busy       = (state != IDLE);
    done       = 1'b0;
    err        = 1'b0;
    case (state)
      IDLE: begin
        if (exc_req)       state_n = (exc_mode > 3'd5)  ? ERR : X_RD_PC;
        else if (eret_req) state_n = (eret_mode > 3'd5) ? ERR : R_RD_ELR;
      end
      X_RD_PC:   begin rf.rd_reg1 = REG_PC;   cap_ld = 1'b1; state_n = X_WR_ELR; end
      X_WR_ELR:  begin rf.wr_reg = REG_ELR;  rf.wr = 1'b1; rf.din = cap;     state_n = X_RD_CPSR; end
      X_RD_CPSR: begin rf.rd_reg1 = REG_CPSR; cap_ld = 1'b1; state_n = X_WR_SPSR; end
      X_WR_SPSR: begin rf.wr_reg = spsr_idx; rf.wr = 1'b1; rf.din = cap_psr; state_n = X_WR_ESR; end
      X_WR_ESR:  begin rf.wr_reg = REG_ESR;  rf.wr = 1'b1; rf.din = syn_q;   state_n = X_RD_EVP; end
      X_RD_EVP:  begin rf.rd_reg1 = REG_EVP;  cap_ld = 1'b1; state_n = X_WR_PC; end
      X_WR_PC:   begin rf.wr_reg = REG_PC;   rf.wr = 1'b1; rf.din = cap + vec_off; state_n = DONE; end
      R_RD_ELR:  begin rf.rd_reg1 = REG_ELR;  cap_ld = 1'b1; state_n = R_WR_PC; end
      R_WR_PC:   begin rf.wr_reg = REG_PC;   rf.wr = 1'b1; rf.din = cap;     state_n = R_RD_SPSR; end
      R_RD_SPSR: begin rf.rd_reg1 = spsr_idx; cap_ld = 1'b1; state_n = R_WR_CPSR; end
      R_WR_CPSR: begin rf.wr_reg = REG_CPSR; rf.wr = 1'b1; rf.din = cap_psr; state_n = DONE; end
      DONE:      begin done = 1'b1; state_n = IDLE; end
      ERR:       begin err  = 1'b1; state_n = IDLE; end
      default:   state_n = IDLE;
    endcase
  end
endmodule

// File: tb/tb_reg_ctx_sequencer.sv
// tb/tb_reg_ctx_sequencer.sv - directed self-checking bench for reg_ctx_sequencer
module tb_reg_ctx_sequencer;
  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        exc_req = 1'b0;
  logic [2:0]  exc_mode = 3'd0;
  logic [7:0]  exc_vec = 8'd0;
  logic [63:0] exc_syndrome = 64'd0;
  logic        eret_req = 1'b0;
  logic [2:0]  eret_mode = 3'd0;
  logic        busy, done, err;

  reg_ctx_sequencer_if #(.DATA_W(64)) rf_bus ();

  reg_ctx_sequencer #(.DATA_W(64)) dut (
    .clk(clk), .rst_n(rst_n),
    .exc_req(exc_req), .exc_mode(exc_mode), .exc_vec(exc_vec), .exc_syndrome(exc_syndrome),
    .eret_req(eret_req), .eret_mode(eret_mode),
    .rf(rf_bus), .busy(busy), .done(done), .err(err)
  );

  always #5 clk = ~clk;

  // Register file model; a write coinciding with a reset edge is not committed.
  logic [63:0] mem [0:63];
  logic        pre_we = 1'b0;
  logic [5:0]  pre_idx = 6'd0;
  logic [63:0] pre_val = 64'd0;
  assign rf_bus.dout1 = mem[rf_bus.rd_reg1];
  always @(posedge clk) begin
    if (pre_we) mem[pre_idx] <= pre_val;
    else if (rst_n && rf_bus.wr) mem[rf_bus.wr_reg] <= rf_bus.din;
  end

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int wr_total = 0, done_total = 0, err_total = 0, done_cyc = 0, err_cyc = 0;
  always @(negedge clk) begin
    if (rf_bus.wr) wr_total++;
    if (done) begin done_total++; done_cyc = cyc; end
    if (err)  begin err_total++;  err_cyc  = cyc; end
  end

  int n_checks = 0, n_pass = 0;
  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic run(input int n);
    repeat (n) tick();
  endtask

  task automatic preload(input logic [5:0] idx, input logic [63:0] val);
    pre_idx = idx; pre_val = val; pre_we = 1'b1;
    tick();
    pre_we = 1'b0;
  endtask

  logic [63:0] snap [0:63];
  int t0, wb, db, eb, diffs;

  initial begin
    for (int i = 0; i < 64; i++) mem[i] = 64'h1111_0000 + 64'(i);

    // Reset state
    run(2);
    check("rst_busy", busy, 0);
    check("rst_done", done, 0);
    check("rst_err", err, 0);
    check("rst_wr", rf_bus.wr, 0);
    check("rst_rd_reg1", rf_bus.rd_reg1, 0);
    check("rst_rd_reg2", rf_bus.rd_reg2, 0);
    check("rst_wr_reg", rf_bus.wr_reg, 0);
    check("rst_din", rf_bus.din, 0);
    check("rst_set_flags", rf_bus.set_flags, 0);
    rst_n = 1'b1;
    tick();

    // Exception entry, inputs scrambled after acceptance
    preload(6'd32, 64'h1000); preload(6'd35, 64'h0A5); preload(6'd43, 64'h8000);
    wb = wr_total; db = done_total;
    exc_mode = 3'd2; exc_vec = 8'd3; exc_syndrome = 64'hDEAD; exc_req = 1'b1;
    tick();
    exc_req = 1'b0; exc_mode = 3'd5; exc_vec = 8'hFF; exc_syndrome = 64'd0; t0 = cyc;
    check("x_c1_rd_reg1", rf_bus.rd_reg1, 32);
    check("x_c1_wr", rf_bus.wr, 0);
    tick();
    check("x_c2_wr_reg", rf_bus.wr_reg, 34);
    check("x_c2_din", rf_bus.din, 64'h1000);
    run(2);
    check("x_c4_wr_reg", rf_bus.wr_reg, 38);
    check("x_c4_din", rf_bus.din, 64'h0A5);
    run(4);
    check("x_c8_done", done, 1);
    check("x_c8_wr", rf_bus.wr, 0);
    tick();
    check("x_c9_busy", busy, 0);
    check("x_done_cycle", 64'(done_cyc - t0 + 1), 8);
    check("x_wr_count", 64'(wr_total - wb), 4);
    check("x_done_count", 64'(done_total - db), 1);
    check("x_elr", mem[34], 64'h1000);
    check("x_spsr2", mem[38], 64'h0A5);
    check("x_esr", mem[33], 64'hDEAD);
    check("x_pc", mem[32], 64'h8030);

    // ERET
    preload(6'd34, 64'h2468); preload(6'd40, 64'h3C1);
    for (int i = 0; i < 64; i++) snap[i] = mem[i];
    wb = wr_total;
    eret_mode = 3'd4; eret_req = 1'b1;
    tick();
    eret_req = 1'b0; t0 = cyc;
    check("r_c1_rd_reg1", rf_bus.rd_reg1, 34);
    run(2);
    check("r_c3_rd_reg1", rf_bus.rd_reg1, 40);
    run(2);
    check("r_c5_done", done, 1);
    tick();
    check("r_done_cycle", 64'(done_cyc - t0 + 1), 5);
    check("r_wr_count", 64'(wr_total - wb), 2);
    check("r_pc", mem[32], 64'h2468);
    check("r_cpsr", mem[35], 64'h3C1);
    diffs = 0;
    for (int i = 0; i < 64; i++)
      if (i != 32 && i != 35 && mem[i] !== snap[i]) diffs++;
    check("r_others_unchanged", 64'(diffs), 0);

    // Simultaneous requests, eret held through DONE
    exc_mode = 3'd0; exc_vec = 8'd0; eret_mode = 3'd0;
    exc_req = 1'b1; eret_req = 1'b1;
    tick();
    exc_req = 1'b0; t0 = cyc;
    check("both_c1_rd_reg1", rf_bus.rd_reg1, 32);
    run(7);
    check("both_c8_done", done, 1);
    tick();
    check("both_c9_busy", busy, 0);
    tick();
    check("both_c10_busy", busy, 1);
    check("both_c10_rd_reg1", rf_bus.rd_reg1, 34);
    eret_req = 1'b0;
    run(5);
    check("both_eret_done_cycle", 64'(done_cyc - t0 + 1), 14);

    // Rejected modes
    wb = wr_total; eb = err_total;
    exc_mode = 3'd6; exc_req = 1'b1;
    tick();
    exc_req = 1'b0; t0 = cyc;
    check("err6_c1_err", err, 1);
    tick();
    check("err6_c2_busy", busy, 0);
    check("err6_c2_err", err, 0);
    eret_mode = 3'd7; eret_req = 1'b1;
    tick();
    eret_req = 1'b0;
    check("err7_c1_err", err, 1);
    tick();
    check("err7_c2_busy", busy, 0);
    check("err_count", 64'(err_total - eb), 2);
    check("err_wr_count", 64'(wr_total - wb), 0);

    // PC wrap with an ignored mid-sequence request
    preload(6'd32, 64'h4440); preload(6'd43, 64'hFFFF_FFFF_FFFF_FFF0);
    wb = wr_total; db = done_total;
    exc_mode = 3'd0; exc_vec = 8'd1; exc_req = 1'b1;
    tick();
    exc_req = 1'b0; t0 = cyc;
    tick();
    exc_mode = 3'd1; exc_req = 1'b1;
    tick();
    exc_req = 1'b0;
    run(8);
    check("wrap_pc", mem[32], 64'd0);
    check("wrap_elr", mem[34], 64'h4440);
    check("wrap_done_count", 64'(done_total - db), 1);
    check("wrap_wr_count", 64'(wr_total - wb), 4);
    check("wrap_idle", busy, 0);

    // Reset in X_WR_SPSR
    preload(6'd32, 64'hABC0); preload(6'd35, 64'h123);
    preload(6'd34, 64'h5555); preload(6'd37, 64'h7777);
    db = done_total; eb = err_total;
    exc_mode = 3'd1; exc_vec = 8'd2; exc_req = 1'b1;
    tick();
    exc_req = 1'b0;
    run(3);
    check("rst4_wr", rf_bus.wr, 1);
    check("rst4_wr_reg", rf_bus.wr_reg, 37);
    rst_n = 1'b0;
    tick();
    check("rst5_busy", busy, 0);
    check("rst5_wr", rf_bus.wr, 0);
    check("rst5_wr_reg", rf_bus.wr_reg, 0);
    check("rst5_din", rf_bus.din, 0);
    check("rst5_rd_reg1", rf_bus.rd_reg1, 0);
    rst_n = 1'b1;
    run(10);
    check("rst_elr_written", mem[34], 64'hABC0);
    check("rst_spsr_kept", mem[37], 64'h7777);
    check("rst_no_done", 64'(done_total - db), 0);
    check("rst_no_err", 64'(err_total - eb), 0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end
endmodule
